mem_access: RTL and testbench

Memory-stage engine between the EX/MEM register and mem_wb. It takes the ALU result as a data address and runs a multi-cycle request/ready handshake with data memory. It handles byte, half and word lanes with load extension, and drives mem_wb's inResult/inReadData/inWriteRegister/inMemToReg/inRegWrite. It stalls the upstream pipeline while an access is outstanding and aborts accesses that exceed a timeout.

---
 rtl/mem_access_if.sv | 21 ++
 rtl/mem_access.sv | 196 +++++++++++++++++++
 tb/tb_mem_access.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_if.sv
// Data-memory request/ready bus between the memory-stage engine (master)
// and the data memory (slave).
interface mem_access_if;
    logic [31:0] memAddr;
    logic [31:0] memWriteData;
    logic [3:0]  memByteEnable;
    logic        memRead;
    logic        memWrite;
    logic        memReady;
    logic [31:0] memReadData;

    modport master (
        output memAddr, memWriteData, memByteEnable, memRead, memWrite,
        input  memReady, memReadData
    );

    modport slave (
        input  memAddr, memWriteData, memByteEnable, memRead, memWrite,
        output memReady, memReadData
    );
endinterface

// File: rtl/mem_access.sv
// Memory-stage engine: turns the EX/MEM instruction into a multi-cycle data
// memory access with lane handling, load extension, pipeline stall and timeout.
//
// state | meaning
// IDLE  | pass-through; issues a request for an aligned load/store
// BUSY  | request outstanding, waiting for memReady or timeout
// DONE  | access finished; held instruction presented to mem_wb for one cycle
module mem_access #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        inValid,
    input  logic [31:0] inResult,
    input  logic [31:0] inWriteData,
    input  logic [4:0]  inWriteRegister,
    input  logic        inMemRead,
    input  logic        inMemWrite,
    input  logic        inMemToReg,
    input  logic        inRegWrite,
    input  logic [1:0]  inSize,
    input  logic        inUnsigned,
    mem_access_if.master memBus,
    output logic [31:0] outResult,
    output logic [31:0] outReadData,
    output logic [4:0]  outWriteRegister,
    output logic        outMemToReg,
    output logic        outRegWrite,
    output logic        outStall,
    output logic        outMisaligned,
    output logic        outBusError
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} stateType;

    stateType         state;
    stateType         nextState;
    logic [CNT_W-1:0] count;
    logic [31:0]      readBuffer;
    logic             aborted;

    logic        memOp;
    logic        aligned;
    logic        issue;
    logic        timeoutHit;
    logic [3:0]  byteEnable;
    logic [31:0] laneData;
    logic [7:0]  loadByte;
    logic [15:0] loadHalf;
    logic [31:0] loadValue;
    logic        stallRaw;
    logic        regWriteRaw;
    logic        misalignedRaw;

    assign memOp      = inValid & (inMemRead | inMemWrite);
    assign issue      = (state == IDLE) & memOp & aligned;
    assign timeoutHit = (count == CNT_W'(TIMEOUT - 1));

    always_comb begin
        aligned    = 1'b1;
        byteEnable = 4'b1111;
        laneData   = inWriteData;
        case (inSize)
            2'b00: begin
                byteEnable = 4'b0001 << inResult[1:0];
                laneData   = {4{inWriteData[7:0]}};
            end
            2'b01: begin
                aligned    = ~inResult[0];
                byteEnable = inResult[1] ? 4'b1100 : 4'b0011;
                laneData   = {2{inWriteData[15:0]}};
            end
            default: begin
                aligned = (inResult[1:0] == 2'b00);
            end
        endcase
    end

    // Little-endian lane pick from the returned word, then sign/zero extend.
    always_comb begin
        case (inResult[1:0])
            2'b00:   loadByte = memBus.memReadData[7:0];
            2'b01:   loadByte = memBus.memReadData[15:8];
            2'b10:   loadByte = memBus.memReadData[23:16];
            default: loadByte = memBus.memReadData[31:24];
        endcase
        loadHalf = inResult[1] ? memBus.memReadData[31:16] : memBus.memReadData[15:0];
        case (inSize)
            2'b00:   loadValue = {{24{~inUnsigned & loadByte[7]}}, loadByte};
            2'b01:   loadValue = {{16{~inUnsigned & loadHalf[15]}}, loadHalf};
            default: loadValue = memBus.memReadData;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (issue) nextState = BUSY;
            BUSY:    if (memBus.memReady || timeoutHit) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        outResult        = inResult;
        outReadData      = 32'd0;
        outWriteRegister = inWriteRegister;
        outMemToReg      = inMemToReg;
        regWriteRaw      = 1'b0;
        stallRaw         = 1'b0;
        misalignedRaw    = 1'b0;
        outBusError      = 1'b0;
        case (state)
            IDLE: begin
                if (issue) begin
                    stallRaw = 1'b1;
                end else if (memOp) begin
                    misalignedRaw = 1'b1;
                end else begin
                    regWriteRaw = inRegWrite & inValid;
                end
            end
            BUSY: begin
                stallRaw = 1'b1;
            end
            DONE: begin
                outReadData = readBuffer;
                regWriteRaw = inRegWrite & ~aborted;
                outBusError = aborted;
            end
            default: begin
                stallRaw = 1'b0;
            end
        endcase
    end

    // Reset low must release the pipeline and block writeback without waiting for a clock.
    assign outStall      = stallRaw & reset;
    assign outRegWrite   = regWriteRaw & reset;
    assign outMisaligned = misalignedRaw & reset;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            memBus.memRead       <= 1'b0;
            memBus.memWrite      <= 1'b0;
            memBus.memAddr       <= 32'd0;
            memBus.memWriteData  <= 32'd0;
            memBus.memByteEnable <= 4'd0;
            readBuffer           <= 32'd0;
            count                <= '0;
            aborted              <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        memBus.memRead       <= inMemRead;
                        memBus.memWrite      <= inMemWrite & ~inMemRead;
                        memBus.memAddr       <= {inResult[31:2], 2'b00};
                        memBus.memByteEnable <= byteEnable;
                        memBus.memWriteData  <= laneData;
                        count                <= '0;
                        aborted              <= 1'b0;
                    end
                end
                BUSY: begin
                    count <= count + 1'b1;
                    if (memBus.memReady) begin
                        memBus.memRead  <= 1'b0;
                        memBus.memWrite <= 1'b0;
                        if (memBus.memRead) begin
                            readBuffer <= loadValue;
                        end
                    end else if (timeoutHit) begin
                        memBus.memRead  <= 1'b0;
                        memBus.memWrite <= 1'b0;
                        aborted         <= 1'b1;
                    end
                end
                default: begin
                    aborted <= aborted;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: per-instruction behavioural model with
// random instructions and memory latencies, plus directed scenarios.
module tb_mem_access;

    localparam int TIMEOUT = 16;

    typedef struct {
        logic        valid;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        uns;
        logic        regWrite;
        logic        memToReg;
        logic [4:0]  wreg;
        int          readyAt;
        logic [31:0] rdata;
    } opType;

    logic        clock;
    logic        reset;
    logic        inValid;
    logic [31:0] inResult;
    logic [31:0] inWriteData;
    logic [4:0]  inWriteRegister;
    logic        inMemRead;
    logic        inMemWrite;
    logic        inMemToReg;
    logic        inRegWrite;
    logic [1:0]  inSize;
    logic        inUnsigned;
    logic [31:0] outResult;
    logic [31:0] outReadData;
    logic [4:0]  outWriteRegister;
    logic        outMemToReg;
    logic        outRegWrite;
    logic        outStall;
    logic        outMisaligned;
    logic        outBusError;

    mem_access_if bus ();

    mem_access #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clock(clock),
        .reset(reset),
        .inValid(inValid),
        .inResult(inResult),
        .inWriteData(inWriteData),
        .inWriteRegister(inWriteRegister),
        .inMemRead(inMemRead),
        .inMemWrite(inMemWrite),
        .inMemToReg(inMemToReg),
        .inRegWrite(inRegWrite),
        .inSize(inSize),
        .inUnsigned(inUnsigned),
        .memBus(bus.master),
        .outResult(outResult),
        .outReadData(outReadData),
        .outWriteRegister(outWriteRegister),
        .outMemToReg(outMemToReg),
        .outRegWrite(outRegWrite),
        .outStall(outStall),
        .outMisaligned(outMisaligned),
        .outBusError(outBusError)
    );

    int errors = 0;
    int checks = 0;

    // Expected values for the current cycle, published by the driver.
    logic        expOn = 1'b0;
    logic        expStall, expRegWrite, expMis, expBusErr, expMemRead, expMemWrite;
    logic        expChkPass, expChkRead, expChkBus;
    logic [31:0] expResult, expReadData, expAddr, expWdata;
    logic [4:0]  expWreg;
    logic        expMemToReg;
    logic [3:0]  expBe;
    int          stallCnt;
    logic [31:0] lastRead;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int laneBytes(input logic [1:0] size);
        return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [3:0] modelBe(input logic [1:0] size, input int off);
        int n = laneBytes(size);
        int mask = ((1 << n) - 1) << off;
        return mask[3:0];
    endfunction

    // Byte lane i carries store-data byte (i mod width).
    function automatic logic [31:0] modelWdata(input logic [31:0] d, input logic [1:0] size);
        logic [31:0] r;
        int n = laneBytes(size);
        r = 32'd0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] modelLoad(input logic [31:0] word, input int off,
                                              input logic [1:0] size, input logic uns);
        int n = laneBytes(size);
        logic [31:0] v, mask;
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * n)) - 32'h1);
        v = (word >> (8 * off)) & mask;
        if (!uns && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    always @(negedge clock) begin
        if (expOn) begin
            check("outStall", {31'd0, outStall}, {31'd0, expStall});
            check("outRegWrite", {31'd0, outRegWrite}, {31'd0, expRegWrite});
            check("outMisaligned", {31'd0, outMisaligned}, {31'd0, expMis});
            check("outBusError", {31'd0, outBusError}, {31'd0, expBusErr});
            check("memRead", {31'd0, bus.memRead}, {31'd0, expMemRead});
            check("memWrite", {31'd0, bus.memWrite}, {31'd0, expMemWrite});
            if (expChkPass) begin
                check("outResult", outResult, expResult);
                check("outWriteRegister", {27'd0, outWriteRegister}, {27'd0, expWreg});
                check("outMemToReg", {31'd0, outMemToReg}, {31'd0, expMemToReg});
            end
            if (expChkRead) check("outReadData", outReadData, expReadData);
            if (expChkBus) begin
                check("memAddr", bus.memAddr, expAddr);
                check("memByteEnable", {28'd0, bus.memByteEnable}, {28'd0, expBe});
                check("memWriteData", bus.memWriteData, expWdata);
            end
        end
    end

    task automatic stepCycle();
        #3;
        if (outStall) stallCnt++;
        lastRead = outReadData;
        @(posedge clock);
        #1;
    endtask

    task automatic randomIdleReady();
        bus.memReady    = $urandom_range(0, 1);
        bus.memReadData = $urandom;
    endtask

    task automatic clearExp();
        expStall    = 1'b0;
        expRegWrite = 1'b0;
        expMis      = 1'b0;
        expBusErr   = 1'b0;
        expMemRead  = 1'b0;
        expMemWrite = 1'b0;
        expChkPass  = 1'b0;
        expChkRead  = 1'b0;
        expChkBus   = 1'b0;
        expReadData = 32'd0;
    endtask

    task automatic runOp(input opType op);
        logic memOp, aligned, isLoad, timedOut;
        int   n, off, k;
        n       = laneBytes(op.size);
        off     = int'(op.addr[1:0]);
        memOp   = op.valid & (op.rd | op.wr);
        aligned = (off % n) == 0;
        isLoad  = op.rd;
        inValid = op.valid; inResult = op.addr; inWriteData = op.wdata;
        inWriteRegister = op.wreg; inMemRead = op.rd; inMemWrite = op.wr;
        inMemToReg = op.memToReg; inRegWrite = op.regWrite; inSize = op.size;
        inUnsigned = op.uns;
        expResult = op.addr; expWreg = op.wreg; expMemToReg = op.memToReg;
        stallCnt = 0;
        clearExp();
        expOn = 1'b1;
        if (!memOp) begin
            expRegWrite = op.regWrite & op.valid;
            expChkPass  = 1'b1;
            expChkRead  = 1'b1;
            randomIdleReady();
            stepCycle();
        end else if (!aligned) begin
            expMis = 1'b1;
            randomIdleReady();
            stepCycle();
        end else begin
            expStall = 1'b1;
            randomIdleReady();
            stepCycle();
            timedOut    = !(op.readyAt >= 1 && op.readyAt <= TIMEOUT);
            expChkBus   = 1'b1;
            expMemRead  = isLoad;
            expMemWrite = !isLoad;
            expAddr     = {op.addr[31:2], 2'b00};
            expBe       = modelBe(op.size, off);
            expWdata    = modelWdata(op.wdata, op.size);
            k = 1;
            while (1) begin
                bus.memReady    = (k == op.readyAt);
                bus.memReadData = (k == op.readyAt) ? op.rdata : $urandom;
                stepCycle();
                if (k == op.readyAt || k == TIMEOUT) break;
                k++;
            end
            clearExp();
            expRegWrite = op.regWrite & !timedOut;
            expBusErr   = timedOut;
            expChkPass  = 1'b1;
            expChkRead  = isLoad & !timedOut;
            expReadData = modelLoad(op.rdata, off, op.size, op.uns);
            randomIdleReady();
            stepCycle();
        end
        expOn = 1'b0;
    endtask

    function automatic opType mkOp(input logic rd, input logic wr, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [1:0] size,
                                   input logic uns, input logic regWrite, input int readyAt,
                                   input logic [31:0] rdata);
        opType o;
        o.valid = 1'b1; o.rd = rd; o.wr = wr; o.addr = addr; o.wdata = wdata;
        o.size = size; o.uns = uns; o.regWrite = regWrite; o.memToReg = rd;
        o.wreg = 5'd5; o.readyAt = readyAt; o.rdata = rdata;
        return o;
    endfunction

    initial begin
        opType o;
        int    r;

        bus.memReady = 1'b0; bus.memReadData = 32'd0;
        reset = 1'b0;
        inValid = 1'b1; inResult = 32'h100; inWriteData = 32'd0; inWriteRegister = 5'd3;
        inMemRead = 1'b1; inMemWrite = 1'b0; inMemToReg = 1'b1; inRegWrite = 1'b1;
        inSize = 2'b10; inUnsigned = 1'b0;
        #3;
        check("rst_outStall", {31'd0, outStall}, 32'd0);
        check("rst_outRegWrite", {31'd0, outRegWrite}, 32'd0);
        check("rst_memRead", {31'd0, bus.memRead}, 32'd0);
        check("rst_memByteEnable", {28'd0, bus.memByteEnable}, 32'd0);
        check("rst_memAddr", bus.memAddr, 32'd0);
        check("rst_memWriteData", bus.memWriteData, 32'd0);
        check("rst_outBusError", {31'd0, outBusError}, 32'd0);
        inValid = 1'b0;
        #9 reset = 1'b1;
        @(posedge clock);
        #1;

        // Pin the model against hand-computed values.
        check("model_lb", modelLoad(32'h80FF_0000, 3, 2'b00, 1'b0), 32'hFFFF_FF80);
        check("model_lbu", modelLoad(32'h80FF_0000, 3, 2'b00, 1'b1), 32'h0000_0080);
        check("model_lhu", modelLoad(32'h80FF_0000, 2, 2'b01, 1'b1), 32'h0000_80FF);
        check("model_be_sb", {28'd0, modelBe(2'b00, 1)}, 32'h2);
        check("model_be_sh", {28'd0, modelBe(2'b01, 2)}, 32'hC);
        check("model_wd_sb", modelWdata(32'h0000_00AB, 2'b00), 32'hABAB_ABAB);

        // ALU pass-through
        o = mkOp(1'b0, 1'b0, 32'h1234, 32'd0, 2'b10, 1'b0, 1'b1, 0, 32'd0);
        runOp(o);
        check("alu_stallcnt", stallCnt, 0);

        o = mkOp(1'b1, 1'b0, 32'h100, 32'd0, 2'b10, 1'b0, 1'b1, 1, 32'hDEAD_BEEF);
        runOp(o);
        check("lw_stallcnt", stallCnt, 2);
        check("lw_data", lastRead, 32'hDEAD_BEEF);

        o = mkOp(1'b1, 1'b0, 32'h103, 32'd0, 2'b00, 1'b0, 1'b1, 1, 32'h80FF_0000);
        runOp(o);
        check("lb_data", lastRead, 32'hFFFF_FF80);
        o.uns = 1'b1;
        runOp(o);
        check("lbu_data", lastRead, 32'h0000_0080);
        o = mkOp(1'b1, 1'b0, 32'h102, 32'd0, 2'b01, 1'b1, 1'b1, 2, 32'h80FF_0000);
        runOp(o);
        check("lhu_data", lastRead, 32'h0000_80FF);

        o = mkOp(1'b0, 1'b1, 32'h201, 32'h0000_00AB, 2'b00, 1'b0, 1'b0, 3, 32'd0);
        runOp(o);
        check("sb_stallcnt", stallCnt, 4);

        o = mkOp(1'b1, 1'b0, 32'h102, 32'd0, 2'b10, 1'b0, 1'b1, 1, 32'd0);
        runOp(o);
        check("mis_stallcnt", stallCnt, 0);

        o = mkOp(1'b1, 1'b0, 32'h104, 32'd0, 2'b10, 1'b0, 1'b1, 0, 32'd0);
        runOp(o);
        check("timeout_stallcnt", stallCnt, TIMEOUT + 1);

        // Reset in the middle of an outstanding load.
        inValid = 1'b1; inResult = 32'h300; inMemRead = 1'b1; inMemWrite = 1'b0;
        inSize = 2'b10; inRegWrite = 1'b1; bus.memReady = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        check("midbusy_memRead", {31'd0, bus.memRead}, 32'd1);
        reset = 1'b0;
        #1;
        check("midrst_memRead", {31'd0, bus.memRead}, 32'd0);
        check("midrst_outStall", {31'd0, outStall}, 32'd0);
        check("midrst_memByteEnable", {28'd0, bus.memByteEnable}, 32'd0);
        inValid = 1'b0;
        @(negedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1;
        o = mkOp(1'b0, 1'b0, 32'h55, 32'd0, 2'b10, 1'b0, 1'b1, 0, 32'd0);
        runOp(o);
        check("postrst_stallcnt", stallCnt, 0);

        for (int i = 0; i < 250; i++) begin
            r = $urandom_range(0, 99);
            o.valid    = (r >= 10);
            o.rd       = 1'b0;
            o.wr       = 1'b0;
            if (r >= 40) begin
                if ($urandom_range(0, 1) == 1) o.rd = 1'b1;
                else o.wr = 1'b1;
            end
            o.size     = 2'($urandom_range(0, 3));
            o.addr     = $urandom;
            if ($urandom_range(0, 99) < 80) begin
                if (o.size == 2'b01) o.addr[0] = 1'b0;
                else if (o.size != 2'b00) o.addr[1:0] = 2'b00;
            end
            o.wdata    = $urandom;
            o.uns      = 1'($urandom_range(0, 1));
            o.regWrite = 1'($urandom_range(0, 1));
            o.memToReg = 1'($urandom_range(0, 1));
            o.wreg     = 5'($urandom_range(0, 31));
            o.rdata    = $urandom;
            r = $urandom_range(0, 99);
            if (r < 70)      o.readyAt = $urandom_range(1, 6);
            else if (r < 85) o.readyAt = $urandom_range(10, TIMEOUT);
            else if (r < 95) o.readyAt = 0;
            else             o.readyAt = $urandom_range(TIMEOUT + 1, TIMEOUT + 4);
            runOp(o);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
